codec_reg_arbiter: RTL and testbench

//  Round-robin arbiter that shares one I2C register-write engine among N_REQ

---
 rtl/codec_reg_arbiter.sv | 158 +++++++++++++++
 tb/tb_codec_reg_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/codec_reg_arbiter.sv
// Round-robin arbiter sharing one codec register-write engine.
// Grants are held off until the codec init sequence reports done.
module codec_reg_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic [N_REQ-1:0] req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [9*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] err,
  output logic             wr_valid,
  output logic [6:0]       wr_addr,
  output logic [8:0]       wr_data,
  input  logic             wr_ready,
  input  logic             wr_done,
  input  logic             wr_nack,
  output logic             busy,
  output logic [IDW-1:0]   grant_id
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [IDW-1:0]   rr_ptr, rr_ptr_n;
  logic [IDW-1:0]   grant_id_n;
  logic             err_flag, err_flag_n;
  logic             wr_valid_n, busy_n;
  logic [6:0]       wr_addr_n;
  logic [8:0]       wr_data_n;
  logic [N_REQ-1:0] ack_n, err_n;

  logic             found;
  logic [IDW-1:0]   win_id;
  logic [6:0]       win_addr;
  logic [8:0]       win_data;
  logic             tmo;
  int               j;

  // First set request scanning upward from rr_ptr with wrap.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_addr = '0;
    win_data = '0;
    j        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        win_id   = IDW'(j);
        win_addr = req_addr[7*j +: 7];
        win_data = req_data[9*j +: 9];
      end
    end
  end

  assign tmo = TO_EN && (timer == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (init_done && found) state_n = ISSUE;
      ISSUE: if (wr_ready) state_n = WAIT;
      WAIT:  if (wr_done || tmo) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wr_valid_n = wr_valid;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    grant_id_n = grant_id;
    rr_ptr_n   = rr_ptr;
    timer_n    = timer;
    err_flag_n = err_flag;
    ack_n      = '0;
    err_n      = '0;
    busy_n     = (state_n != IDLE);
    unique case (state)
      IDLE: begin
        if (state_n == ISSUE) begin
          grant_id_n = win_id;
          wr_addr_n  = win_addr;
          wr_data_n  = win_data;
          wr_valid_n = 1'b1;
        end
      end
      ISSUE: begin
        if (wr_ready) begin
          wr_valid_n = 1'b0;
          timer_n    = '0;
        end
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        // wr_done takes priority over a coincident timeout
        if (wr_done)  err_flag_n = wr_nack;
        else if (tmo) err_flag_n = 1'b1;
        if (state_n == RESP) begin
          for (int i = 0; i < N_REQ; i++) begin
            ack_n[i] = (grant_id == IDW'(i));
            err_n[i] = (grant_id == IDW'(i)) && err_flag_n;
          end
          if (int'(grant_id) == N_REQ - 1) rr_ptr_n = '0;
          else rr_ptr_n = grant_id + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      timer    <= '0;
      err_flag <= 1'b0;
      ack      <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      grant_id <= grant_id_n;
      rr_ptr   <= rr_ptr_n;
      timer    <= timer_n;
      err_flag <= err_flag_n;
      ack      <= ack_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Scoreboard bench for codec_reg_arbiter: round-robin order,
// init gating, NACK/timeout responses and async reset.
module tb_codec_reg_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init_done = 1'b0;
  logic [N-1:0] req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [9*N-1:0] req_data = '0;
  logic [N-1:0] ack, err;
  logic         wr_valid;
  logic [6:0]   wr_addr;
  logic [8:0]   wr_data;
  logic         wr_ready = 1'b0;
  logic         wr_done = 1'b0;
  logic         wr_nack = 1'b0;
  logic         busy;
  logic [1:0]   grant_id;

  codec_reg_arbiter #(.N_REQ(N), .IDW(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [6:0] addr;
    logic [8:0] data;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   mptr = 0;
  int   w;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.id   = pick(req, mptr);
    e.addr = req_addr[7*e.id +: 7];
    e.data = req_data[9*e.id +: 9];
    q.push_back(e);
  endtask

  function automatic logic [27:0] outs();
    return {ack, err, wr_valid, wr_addr, wr_data, busy, grant_id};
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wr_valid_seen", wr_valid, 1);
  endtask

  task automatic check_grant(output exp_t e);
    chk("sb_depth", q.size(), 1);
    e.id = 0; e.addr = '0; e.data = '0;
    if (q.size() > 0) e = q.pop_front();
    chk("grant_id", grant_id, e.id);
    chk("wr_addr", wr_addr, e.addr);
    chk("wr_data", wr_data, e.data);
  endtask

  task automatic serve(input int lat, input bit nack, input bit tmo,
                       output int waited);
    exp_t e;
    wait_valid(waited);
    check_grant(e);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("wr_valid_drop", wr_valid, 0);
    chk("busy_wait", busy, 1);
    if (tmo) begin
      repeat (TO - 1) tick();
      chk("ack_early", ack, 0);
      tick();
    end else begin
      repeat (lat) tick();
      wr_done = 1'b1;
      wr_nack = nack;
      tick();
      wr_done = 1'b0;
      wr_nack = 1'b0;
    end
    chk("ack", ack, 32'(1) << e.id);
    chk("err", err, (tmo || nack) ? (32'(1) << e.id) : 0);
    req[e.id] = 1'b0;
    mptr = (e.id + 1) % N;
    tick();
    chk("ack_pulse", ack, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   id;
    bit   seen;
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7] = 7'(8'h10 + i);
      req_data[9*i +: 9] = 9'(12'h100 + 3 * i);
    end
    // reset held with live requests
    req = 4'b1111;
    init_done = 1'b1;
    repeat (3) tick();
    chk("reset_outs", 32'(outs()), 0);
    rst = 1'b1;
    push_exp();
    // continuous requests: order 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      id = pick(req, mptr);
      chk("rr_order", id, t % N);
      serve(2 + t, (id == 2), 1'b0, w);
      req[id] = 1'b1;
      if (t < 4) push_exp();
    end
    req = '0;
    repeat (3) tick();
    // init gating
    init_done = 1'b0;
    req_addr[7 +: 7] = 7'h04;
    req_data[9 +: 9] = 9'h015;
    req = 4'b0010;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_valid) seen = 1'b1;
    end
    chk("gated_valid", seen, 0);
    init_done = 1'b1;
    push_exp();
    serve(1, 1'b0, 1'b0, w);
    chk("init_latency", w, 1);
    // timeout, and done on the last timeout cycle
    req = 4'b0001;
    push_exp();
    serve(0, 1'b0, 1'b1, w);
    req = 4'b0001;
    push_exp();
    serve(TO - 1, 1'b0, 1'b0, w);
    // reset mid-WAIT
    req = 4'b0100;
    push_exp();
    wait_valid(w);
    check_grant(e);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    tick();
    tick();
    chk("busy_pre_rst", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 0);
    mptr = 0;
    req = 4'b1001;
    tick();
    tick();
    rst = 1'b1;
    push_exp();
    serve(3, 1'b0, 1'b0, w);
    push_exp();
    serve(1, 1'b1, 1'b0, w);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
